// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event queue.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam int ROW_BITS      = 4;
  localparam int COL_BITS      = 4;
  localparam int DEFAULT_DEPTH = 4;

  // Result of a one-hot nibble decode: index (bit3 = 0) plus a valid flag.
  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_idx_t;

  // Zero or multiple set bits are flagged invalid; the MSB maps to index 0.
  function automatic onehot_idx_t onehot4_to_idx(input logic [3:0] v);
    onehot_idx_t r;
    r = '0;
    case (v)
      4'b1000: r = '{valid: 1'b1, idx: 2'd0};
      4'b0100: r = '{valid: 1'b1, idx: 2'd1};
      4'b0010: r = '{valid: 1'b1, idx: 2'd2};
      4'b0001: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '{valid: 1'b0, idx: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational keypad vector decoder: row/column one-hot nibbles to a 4-bit code.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [ROW_BITS+COL_BITS-1:0] button,
  output logic                         key_valid_in,
  output key_code_t                    code
);

  onehot_idx_t row;
  onehot_idx_t col;

  // A key is valid only when both nibbles are one-hot; code = row*4 + col.
  always_comb begin
    row          = onehot4_to_idx(button[7:4]);
    col          = onehot4_to_idx(button[3:0]);
    key_valid_in = row.valid & col.valid;
    code         = {row.idx, col.idx};
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad event FIFO: decodes pushed keys, queues them first-word-fall-through,
// and reports malformed pushes and dropped keys.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Push,
  input  logic [7:0]               Button,
  output key_code_t                key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     bad_key,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_code_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              dec_valid;
  key_code_t         dec_code;
  logic              valid_push;
  logic              full;
  logic              do_push;
  logic              do_pop;

  keypad_decode u_decode (
    .button       (Button),
    .key_valid_in (dec_valid),
    .code         (dec_code)
  );

  // Handshake qualification; a pop on a full queue frees the slot the push needs.
  always_comb begin
    valid_push = Push & dec_valid;
    full       = (count == CW'(DEPTH));
    key_valid  = (count != '0);
    do_pop     = key_valid & key_ready;
    do_push    = valid_push & (~full | do_pop);
  end

  // Head is driven straight from storage and forced to zero while empty.
  always_comb begin
    key_code = key_valid ? mem[rd_ptr] : '0;
  end

  // Storage RAM, intentionally not reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= dec_code;
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bad_key  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bad_key <= Push & ~dec_valid;
      if (valid_push & full & ~do_pop) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench for keypad_event_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_keypad_event_queue;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       Push;
  logic [7:0] Button;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] count;
  logic       bad_key;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  bit m_ovf;
  bit m_bad;

  keypad_event_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .Push      (Push),
    .Button    (Button),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .count     (count),
    .bad_key   (bad_key),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endfunction

  // Returns index of the single set bit (MSB = 0) or -1 if not one-hot.
  function automatic int nib_idx(input logic [3:0] n);
    int ones = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++) begin
      if (n[3-i]) begin
        ones++;
        pos = i;
      end
    end
    return (ones == 1) ? pos : -1;
  endfunction

  function automatic void model_edge(input logic p, input logic [7:0] b, input logic rdy);
    int r;
    int c;
    r = nib_idx(b[7:4]);
    c = nib_idx(b[3:0]);
    if (rdy && q.size() > 0) void'(q.pop_front());
    m_bad = 1'b0;
    if (p) begin
      if (r < 0 || c < 0) m_bad = 1'b1;
      else if (q.size() < DEPTH) q.push_back(r * 4 + c);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_compare(string tag);
    chk({tag, ".valid"},    int'(key_valid), (q.size() > 0) ? 1 : 0);
    chk({tag, ".code"},     int'(key_code),  (q.size() > 0) ? q[0] : 0);
    chk({tag, ".count"},    int'(count),     q.size());
    chk({tag, ".bad_key"},  int'(bad_key),   int'(m_bad));
    chk({tag, ".overflow"}, int'(overflow),  int'(m_ovf));
  endfunction

  // Called at a negedge: drive, take one rising edge, compare just after it.
  task automatic step(input logic p, input logic [7:0] b, input logic rdy, input string tag);
    Push = p;
    Button = b;
    key_ready = rdy;
    @(posedge clock);
    model_edge(p, b, rdy);
    #1;
    model_compare(tag);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Push = 1'b0;
    Button = '0;
    key_ready = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       push;
    logic [7:0] button;
    logic       ready;
    logic       e_valid;
    int         e_code;
    int         e_count;
    logic       e_bad;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [3:0] one_hot;
    logic [7:0] b;
    logic       p;
    int         rr;
    int         cc;

    tbl[0]  = '{1'b1, 8'b10001000, 1'b0, 1'b1, 0,  1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'b01001000, 1'b0, 1'b1, 0,  2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'b11001000, 1'b0, 1'b1, 0,  2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'b00000000, 1'b0, 1'b1, 0,  2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'b10000000, 1'b0, 1'b1, 0,  2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'b00101000, 1'b0, 1'b1, 0,  3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'b00011000, 1'b0, 1'b1, 0,  4, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'b10000100, 1'b0, 1'b1, 0,  4, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'b01000100, 1'b1, 1'b1, 4,  4, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'b00000000, 1'b1, 1'b1, 8,  3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'b00000000, 1'b1, 1'b1, 12, 2, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'b00000000, 1'b1, 1'b1, 5,  1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'b00000000, 1'b1, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'b00000000, 1'b1, 1'b0, 0,  0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'b00011000, 1'b0, 1'b0, 0,  0, 1'b0, 1'b1};

    reset = 1'b1;
    Push = 1'b0;
    Button = '0;
    key_ready = 1'b0;
    #2;
    chk("reset.valid",    int'(key_valid), 0);
    chk("reset.count",    int'(count),     0);
    chk("reset.code",     int'(key_code),  0);
    chk("reset.bad_key",  int'(bad_key),   0);
    chk("reset.overflow", int'(overflow),  0);
    do_reset();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].push, tbl[i].button, tbl[i].ready, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_valid", i), int'(key_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.exp_code", i),  int'(key_code),  tbl[i].e_code);
      chk($sformatf("tbl%0d.exp_count", i), int'(count),     tbl[i].e_count);
      chk($sformatf("tbl%0d.exp_bad", i),   int'(bad_key),   int'(tbl[i].e_bad));
      chk($sformatf("tbl%0d.exp_ovf", i),   int'(overflow),  int'(tbl[i].e_ovf));
    end

    // Five pushes at 10-cycle spacing, then drain: 4, 8, 12, 1; fifth is lost.
    do_reset();
    step(1'b1, 8'b01001000, 1'b0, "sp0"); repeat (9) step(1'b0, 8'h00, 1'b0, "sp0w");
    step(1'b1, 8'b00101000, 1'b0, "sp1"); repeat (9) step(1'b0, 8'h00, 1'b0, "sp1w");
    step(1'b1, 8'b00011000, 1'b0, "sp2"); repeat (9) step(1'b0, 8'h00, 1'b0, "sp2w");
    step(1'b1, 8'b10000100, 1'b0, "sp3"); repeat (9) step(1'b0, 8'h00, 1'b0, "sp3w");
    step(1'b1, 8'b01000100, 1'b0, "sp4");
    chk("spaced.overflow", int'(overflow), 1);
    chk("spaced.head", int'(key_code), 4);
    step(1'b0, 8'h00, 1'b1, "drain1"); chk("drain1.code", int'(key_code), 8);
    step(1'b0, 8'h00, 1'b1, "drain2"); chk("drain2.code", int'(key_code), 12);
    step(1'b0, 8'h00, 1'b1, "drain3"); chk("drain3.code", int'(key_code), 1);
    step(1'b0, 8'h00, 1'b1, "drain4"); chk("drain4.valid", int'(key_valid), 0);

    // Full queue, push and pop on the same edge; overflow stays clear.
    do_reset();
    step(1'b1, 8'b10001000, 1'b0, "f0");
    step(1'b1, 8'b10000100, 1'b0, "f1");
    step(1'b1, 8'b10000010, 1'b0, "f2");
    step(1'b1, 8'b10000001, 1'b0, "f3");
    step(1'b1, 8'b00010001, 1'b1, "fpp");
    chk("fullpp.count", int'(count), 4);
    chk("fullpp.head", int'(key_code), 1);
    chk("fullpp.ovf", int'(overflow), 0);
    step(1'b0, 8'h00, 1'b1, "fd1");
    step(1'b0, 8'h00, 1'b1, "fd2");
    step(1'b0, 8'h00, 1'b1, "fd3");
    chk("fullpp.tail", int'(key_code), 15);

    // Asynchronous reset with three keys queued and the consumer ready.
    step(1'b1, 8'b01000010, 1'b0, "r0");
    step(1'b1, 8'b00100010, 1'b0, "r1");
    key_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("areset.valid", int'(key_valid), 0);
    chk("areset.count", int'(count), 0);
    chk("areset.code",  int'(key_code), 0);
    do_reset();
    step(1'b1, 8'b10000100, 1'b0, "postrst");
    chk("postrst.code", int'(key_code), 1);
    chk("postrst.count", int'(count), 1);

    // Button ignored while Push is low.
    for (int i = 0; i < 10; i++) step(1'b0, 8'b00011000, 1'b0, "nopush");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 7) begin
        rr = $urandom_range(0, 3);
        cc = $urandom_range(0, 3);
        one_hot = 4'b1000;
        b = {one_hot >> rr, one_hot >> cc};
      end else begin
        b = 8'($urandom);
      end
      step(p, b, ($urandom_range(0, 2) != 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
